// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential signed add-shift multiplier.
// The sign-extension helper is sized for the widest operand the block supports.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Widest operand the helper below can handle.
  localparam int MAX_W = 64;

  // Returns the one extra bit needed to sign-extend a w-bit value by one
  // position, i.e. bit w-1 of v. Callers zero-extend their operand to MAX_W.
  function automatic logic sext1(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    return |(v & mask);
  endfunction

endpackage

// File: rtl/add_sub_n.sv
// Combinational WIDTH-bit adder/subtractor: y = a + b (fn=0) or a - b (fn=1).
// The carry/borrow out is intentionally discarded.
module add_sub_n #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             fn,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = fn ? (a - b) : (a + b);
  end

endmodule

// File: rtl/mult_seq_n.sv
// Sequential signed add-shift multiplier with start/busy/done handshake.
// {X,A,B} is the accumulator/multiplier shift chain; the product is {A,B}.
module mult_seq_n
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_b,
  input  logic               clear_a,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  output logic               busy,
  output logic               done,
  output logic               x_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  state_t             state_q, state_d;
  logic               x_q, x_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               last_iter;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     s_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign a_ext = {sext1(MAX_W'(a_q), WIDTH), a_q};
  assign s_ext = {sext1(MAX_W'(s_q), WIDTH), s_q};

  // The final iteration weighs the multiplier sign bit negatively, so it subtracts.
  add_sub_n #(
    .WIDTH (WIDTH + 1)
  ) u_add_sub (
    .a  (a_ext),
    .b  (s_ext),
    .fn (last_iter),
    .y  (sum)
  );

  assign a_sh = {x_q, a_q[WIDTH-1:1]};
  assign b_sh = {a_q[0], b_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (load_b) begin
          b_d = operand;
        end else if (clear_a) begin
          x_d = 1'b0;
          a_d = '0;
        end else if (start) begin
          s_d     = operand;
          x_d     = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        a_d = a_sh;
        b_d = b_sh;
        if (last_iter) begin
          // Product fits in WIDTH signed bits only if A and X replicate B's MSB.
          ovf_d   = (a_sh != {WIDTH{b_sh[WIDTH-1]}}) || (x_q != b_sh[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ADD;
        end
      end

      DONE: begin
        state_d = start ? HOLD : IDLE;
      end

      HOLD: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ADD) || (state_d == SHIFT) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_out   = x_q;
  assign a_out   = a_q;
  assign b_out   = b_q;
  assign product = {a_q, b_q};
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mult_seq_n.sv
// Randomised self-checking bench for mult_seq_n; reference is a plain signed
// multiply of the current multiplier register and the multiplicand.
module tb_mult_seq_n;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               load_b, clear_a, start;
  logic [W-1:0]       operand;
  logic               busy, done, x_out, ovf;
  logic [W-1:0]       a_out, b_out;
  logic [2*W-1:0]     product;

  logic               load16, clear16, start16;
  logic [W2-1:0]      op16;
  logic               busy16, done16, x16, ovf16;
  logic [W2-1:0]      a16, b16;
  logic [2*W2-1:0]    prod16;

  mult_seq_n #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load_b  (load_b),
    .clear_a (clear_a),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .x_out   (x_out),
    .a_out   (a_out),
    .b_out   (b_out),
    .product (product),
    .ovf     (ovf)
  );

  mult_seq_n #(.WIDTH(W2)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .load_b  (load16),
    .clear_a (clear16),
    .start   (start16),
    .operand (op16),
    .busy    (busy16),
    .done    (done16),
    .x_out   (x16),
    .a_out   (a16),
    .b_out   (b16),
    .product (prod16),
    .ovf     (ovf16)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] model_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_b  = 1'b1;
    operand = v;
    tick();
    load_b  = 1'b0;
    model_b = v;
  endtask

  // One multiply of model_b * mcand; optional junk on load/clear/operand while
  // busy, optional start held high past done.
  task automatic run_mult(input logic [W-1:0] mcand, input bit junk, input bit hold);
    longint         p;
    logic [2*W-1:0] exp_p;
    logic           exp_ovf;
    int             n;
    p       = longint'($signed(model_b)) * longint'($signed(mcand));
    exp_p   = p[2*W-1:0];
    exp_ovf = (p > longint'(2 ** (W - 1) - 1)) || (p < -longint'(2 ** (W - 1)));
    operand = mcand;
    start   = 1'b1;
    tick();
    check("busy_on", 64'(busy), 64'(1));
    if (!hold) start = 1'b0;
    n = 0;
    while (!done && n < 4 * W) begin
      if (junk) begin
        operand = W'($urandom);
        load_b  = 1'($urandom_range(0, 1));
        clear_a = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    load_b  = 1'b0;
    clear_a = 1'b0;
    check("latency", 64'(n), 64'(2 * W));
    check("product", 64'(product), 64'(exp_p));
    check("b_out", 64'(b_out), 64'(exp_p[W-1:0]));
    check("x_out", 64'(x_out), 64'(exp_p[2*W-1]));
    check("ovf", 64'(ovf), 64'(exp_ovf));
    check("busy_at_done", 64'(busy), 64'(1));
    model_b = exp_p[W-1:0];
    tick();
    check("done_pulse", 64'(done), 64'(0));
    check("busy_off", 64'(busy), 64'(0));
    check("ovf_hold", 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    int n16;
    logic [W-1:0] v;
    logic [W-1:0] edge_b [5] = '{8'h80, 8'h7F, 8'hFF, 8'h80, 8'h01};
    logic [W-1:0] edge_s [5] = '{8'h7F, 8'h7F, 8'hFF, 8'h01, 8'h80};

    reset_n = 1'b0;
    load_b  = 1'b0;
    clear_a = 1'b0;
    start   = 1'b0;
    operand = '0;
    load16  = 1'b0;
    clear16 = 1'b0;
    start16 = 1'b0;
    op16    = '0;
    model_b = '0;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_product", 64'(product), 64'(0));
    check("rst_x", 64'(x_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));

    // Directed cases, including consecutive multiply reusing the low half.
    do_load(8'h07);
    run_mult(8'hFD, 1'b0, 1'b0);
    check("tp_m21", 64'(product), 64'(16'hFFEB));
    run_mult(8'h02, 1'b0, 1'b0);
    check("tp_m42", 64'(product), 64'(16'hFFD6));
    do_load(8'h80);
    run_mult(8'h80, 1'b0, 1'b0);
    check("tp_16384", 64'(product), 64'(16'h4000));
    check("tp_ovf", 64'(ovf), 64'(1));
    do_load(8'h05);
    run_mult(8'h00, 1'b1, 1'b0);

    // clear_a in IDLE zeroes X and A, leaves B.
    do_load(8'h33);
    run_mult(8'h7F, 1'b0, 1'b0);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_a", 64'(a_out), 64'(0));
    check("clr_x", 64'(x_out), 64'(0));
    check("clr_b", 64'(b_out), 64'(model_b));

    // start held across DONE: no rerun, load_b ignored in HOLD.
    run_mult(8'h03, 1'b0, 1'b1);
    load_b  = 1'b1;
    operand = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_busy", 64'(busy), 64'(0));
    end
    load_b = 1'b0;
    check("hold_b", 64'(b_out), 64'(model_b));
    start = 1'b0;
    tick();
    tick();
    check("hold_idle", 64'(busy), 64'(0));
    run_mult(8'h05, 1'b0, 1'b0);

    // load_b and start together: only the load happens.
    v       = W'($urandom);
    load_b  = 1'b1;
    start   = 1'b1;
    operand = v;
    tick();
    load_b  = 1'b0;
    start   = 1'b0;
    model_b = v;
    check("ld_st_busy", 64'(busy), 64'(0));
    check("ld_st_b", 64'(b_out), 64'(v));
    tick();
    check("ld_st_busy2", 64'(busy), 64'(0));

    // Reset in the middle of a multiply.
    do_load(8'h6B);
    operand = 8'hC5;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_b = '0;
    check("mrst_product", 64'(product), 64'(0));
    check("mrst_x", 64'(x_out), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    check("mrst_ovf", 64'(ovf), 64'(0));
    tick();
    check("mrst_idle", 64'(busy), 64'(0));
    run_mult(8'h11, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      do_load(edge_b[i]);
      run_mult(edge_s[i], 1'b0, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0) do_load(W'($urandom));
      run_mult(W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    // 16-bit instance regression.
    load16 = 1'b1;
    op16   = 16'h8000;
    tick();
    load16  = 1'b0;
    op16    = 16'h7FFF;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n16 = 0;
    while (!done16 && n16 < 4 * W2) begin
      tick();
      n16++;
    end
    check("w16_latency", 64'(n16), 64'(2 * W2));
    check("w16_product", 64'(prod16), 64'(32'hC0008000));
    check("w16_x", 64'(x16), 64'(1));
    check("w16_ovf", 64'(ovf16), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
